scmp_acc_status: RTL

SCMP_ACC_STATUS -- requirements
Module: scmp_acc_status

---
 rtl/scmp_acc_status_pkg.sv | 24 ++
 rtl/scmp_acc_status_if.sv | 39 +++
 rtl/scmp_acc_status_sync2.sv | 20 ++
 rtl/scmp_acc_status.sv | 123 ++++++++++++
 4 files changed

// File: rtl/scmp_acc_status_pkg.sv
// Shared constants for the SC/MP accumulator/status block: SR bit layout,
// DLY counter sizing and state encoding, and the DLY count helper.
package scmp_microcode_pak;

  localparam int SR_CY = 7;
  localparam int SR_OV = 6;
  localparam int SR_SB = 5;
  localparam int SR_SA = 4;
  localparam int SR_IE = 3;
  localparam int SR_F2 = 2;
  localparam int SR_F0 = 0;

  localparam int              DLY_W    = 18;
  localparam logic [DLY_W-1:0] DLY_BASE = 18'd13;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  // 13 + 2*AC + 2*disp + 512*disp, all terms zero-extended so nothing wraps
  function automatic logic [DLY_W-1:0] dly_count(input logic [7:0] ac, input logic [7:0] disp);
    dly_count = DLY_BASE + {9'd0, ac, 1'b0} + {9'd0, disp, 1'b0} + {1'b0, disp, 9'd0};
  endfunction

endpackage

// File: rtl/scmp_acc_status_if.sv
// Bus between the SC/MP sequencer/ALU and the accumulator/status block.
interface scmp_acc_status_if;
  logic [7:0] alu_res_i;
  logic       alu_cy_i;
  logic       alu_ov_i;
  logic       ld_ac_i;
  logic       ld_e_i;
  logic       ld_sr_i;
  logic       ld_cy_i;
  logic       ld_ov_i;
  logic       sio_i;
  logic       sin_i;
  logic       sa_i;
  logic       sb_i;
  logic       dly_start_i;
  logic [7:0] dly_disp_i;
  logic [7:0] ac_o;
  logic [7:0] e_o;
  logic [7:0] sr_o;
  logic       cy_o;
  logic       ov_o;
  logic [2:0] f_o;
  logic       ie_o;
  logic       sout_o;
  logic       dly_busy_o;
  logic       dly_done_o;

  modport master (
    output alu_res_i, alu_cy_i, alu_ov_i, ld_ac_i, ld_e_i, ld_sr_i, ld_cy_i, ld_ov_i,
           sio_i, sin_i, sa_i, sb_i, dly_start_i, dly_disp_i,
    input  ac_o, e_o, sr_o, cy_o, ov_o, f_o, ie_o, sout_o, dly_busy_o, dly_done_o
  );

  modport slave (
    input  alu_res_i, alu_cy_i, alu_ov_i, ld_ac_i, ld_e_i, ld_sr_i, ld_cy_i, ld_ov_i,
           sio_i, sin_i, sa_i, sb_i, dly_start_i, dly_disp_i,
    output ac_o, e_o, sr_o, cy_o, ov_o, f_o, ie_o, sout_o, dly_busy_o, dly_done_o
  );
endinterface

// File: rtl/scmp_acc_status_sync2.sv
// Two-flop synchroniser for the asynchronous SA/SB sense inputs.
module scmp_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/scmp_acc_status.sv
// SC/MP accumulator, extension and status registers with serial I/O and the
// DLY instruction delay counter. All load/shift strobes are frozen during DLY.
module scmp_acc_status (
  input  logic          clk_i,
  input  logic          rst_i,
  scmp_acc_status_if.slave bus
);
  import scmp_microcode_pak::*;

  logic [7:0]       ac;
  logic [7:0]       e;
  logic             sout;
  logic             sr_cy;
  logic             sr_ov;
  logic             sr_ie;
  logic [2:0]       sr_f;
  logic             sa_sync;
  logic             sb_sync;
  logic [0:0]       state;
  logic [DLY_W-1:0] count;
  logic             done;
  logic             busy;
  logic             idle;
  logic             last;

  assign busy = (state == ST_COUNT);
  assign idle = (state == ST_IDLE);
  assign last = busy && (count == 18'd1);

  scmp_sync2 u_sync_sa (.clk_i(clk_i), .rst_i(rst_i), .d(bus.sa_i), .q(sa_sync));
  scmp_sync2 u_sync_sb (.clk_i(clk_i), .rst_i(rst_i), .d(bus.sb_i), .q(sb_sync));

  // Accumulator: ALU load when idle, forced to FF as DLY completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ac <= 8'h00;
    end else if (last) begin
      ac <= 8'hFF;
    end else if (idle && bus.ld_ac_i) begin
      ac <= bus.alu_res_i;
    end
  end

  // Extension register and serial shifter; a parallel load beats a shift
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e    <= 8'h00;
      sout <= 1'b0;
    end else if (idle) begin
      if (bus.ld_e_i) begin
        e <= bus.alu_res_i;
      end else if (bus.sio_i) begin
        e    <= {bus.sin_i, e[7:1]};
        sout <= e[0];
      end
    end
  end

  // Writable status bits; a full SR load overrides the individual CY/OV loads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_cy <= 1'b0;
      sr_ov <= 1'b0;
      sr_ie <= 1'b0;
      sr_f  <= 3'b000;
    end else if (idle) begin
      if (bus.ld_sr_i) begin
        sr_cy <= bus.alu_res_i[SR_CY];
        sr_ov <= bus.alu_res_i[SR_OV];
        sr_ie <= bus.alu_res_i[SR_IE];
        sr_f  <= bus.alu_res_i[SR_F2:SR_F0];
      end else begin
        if (bus.ld_cy_i) sr_cy <= bus.alu_cy_i;
        if (bus.ld_ov_i) sr_ov <= bus.alu_ov_i;
      end
    end
  end

  // DLY sequencer: done is raised one edge early so it lines up with count==1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      count <= 18'd0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (bus.dly_start_i) begin
            state <= ST_COUNT;
            count <= dly_count(ac, bus.dly_disp_i);
          end
        end
        ST_COUNT: begin
          if (count == 18'd1) begin
            state <= ST_IDLE;
            count <= 18'd0;
            done  <= 1'b0;
          end else begin
            count <= count - 18'd1;
            done  <= (count == 18'd2);
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 18'd0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ac_o       = ac;
  assign bus.e_o        = e;
  assign bus.sr_o       = {sr_cy, sr_ov, sb_sync, sa_sync, sr_ie, sr_f};
  assign bus.cy_o       = sr_cy;
  assign bus.ov_o       = sr_ov;
  assign bus.ie_o       = sr_ie;
  assign bus.f_o        = sr_f;
  assign bus.sout_o     = sout;
  assign bus.dly_busy_o = busy;
  assign bus.dly_done_o = done;
endmodule
